// File: rtl/ram_bus_ctrl_pkg.sv
// ram_bus_ctrl_pkg
//   Shared definitions for the SRAM bus sequencer: command encodings,
//   FSM state encodings and small helpers used by ram_bus_ctrl.
//   No ports (package).
package ram_bus_ctrl_pkg;

    // Command encoding presented by the core on Cmd.
    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_READ  = 2'd0;
    localparam cmd_t CMD_WRITE = 2'd1;
    localparam cmd_t CMD_INC   = 2'd2;
    localparam cmd_t CMD_DEC   = 2'd3;

    // Sequencer states. Each state is exactly the bus phase the chip sees in
    // that cycle, because every chip-facing output is a registered decode of
    // the state being entered.
    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE     = 3'd0;  // CS_n high, waiting for Req
    localparam logic [2:0] ST_ADDR     = 3'd1;  // address/CS settle, strobes high
    localparam logic [2:0] ST_RD       = 3'd2;  // OE_n low for RdWait cycles
    localparam logic [2:0] ST_TURN     = 3'd3;  // bus turnaround, data +/- 1
    localparam logic [2:0] ST_WR_SETUP = 3'd4;  // data driven, WE_n high
    localparam logic [2:0] ST_WR_PULSE = 3'd5;  // WE_n low for WrPulse cycles
    localparam logic [2:0] ST_WR_HOLD  = 3'd6;  // WE_n high, data still driven
    localparam logic [2:0] ST_DONE     = 3'd7;  // Ack cycle

    // Every command except WRITE starts with a read of the cell.
    function automatic logic cmd_reads(input cmd_t cmd);
        return (cmd != CMD_WRITE);
    endfunction

    // INC and DEC write the modified value back after the read.
    function automatic logic cmd_is_rmw(input cmd_t cmd);
        return (cmd == CMD_INC) || (cmd == CMD_DEC);
    endfunction

    // Width of the shared wait counter: it must hold the longer of the two
    // programmable phase lengths.
    function automatic int cnt_width(input int rd_wait, input int wr_pulse);
        int longest;
        longest = (rd_wait > wr_pulse) ? rd_wait : wr_pulse;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl
//   Synchronous sequencer for an asynchronous, active-low SRAM used as data
//   memory. Runs one command at a time: READ, WRITE, INC or DEC (INC/DEC are
//   read-modify-write of the addressed cell, wrapping modulo 2^DataSize).
//   OE_n and WE_n are never low together, and the controller only drives the
//   data bus while the chip's output enable is high.
//
// Ports
//   Clk      in     clock, all state on the rising edge
//   Rst      in     asynchronous reset, active-high
//   Req      in     command valid, only looked at while idle
//   Cmd      in     0=READ 1=WRITE 2=INC 3=DEC
//   Addr     in     cell address
//   WData    in     write data (WRITE only)
//   Busy     out    high from the cycle after accept through the Ack cycle
//   Ack      out    one-cycle completion pulse
//   RData    out    READ: cell value, INC/DEC: new value, WRITE: WData;
//                   held until the next Ack
//   RamAddr  out    chip ADDRESS
//   RamData  inout  chip DATA
//   RamCs_n  out    chip CS (active low)
//   RamWe_n  out    chip WE (active low)
//   RamOe_n  out    chip OE (active low)
//
// Cycle accounting (accept cycle = cycle in which Req is seen in IDLE):
//   READ     ADDR, RD x RdWait, DONE                         -> Ack 2+RdWait
//   WRITE    ADDR, WR_SETUP, WR_PULSE x WrPulse, WR_HOLD, DONE -> 4+WrPulse
//   INC/DEC  ADDR, RD x RdWait, TURN, WR_SETUP, WR_PULSE x WrPulse,
//            WR_HOLD, DONE                                   -> 5+RdWait+WrPulse
module ram_bus_ctrl
    import ram_bus_ctrl_pkg::*;
#(
    parameter int AddressSize = 16,
    parameter int DataSize    = 8,
    parameter int RdWait      = 2,
    parameter int WrPulse     = 2
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Req,
    input  logic [1:0]             Cmd,
    input  logic [AddressSize-1:0] Addr,
    input  logic [DataSize-1:0]    WData,
    output logic                   Busy,
    output logic                   Ack,
    output logic [DataSize-1:0]    RData,
    output logic [AddressSize-1:0] RamAddr,
    inout  wire  [DataSize-1:0]    RamData,
    output logic                   RamCs_n,
    output logic                   RamWe_n,
    output logic                   RamOe_n
);

    localparam int CntW = cnt_width(RdWait, WrPulse);

    localparam logic [CntW-1:0]     CNT_FIRST = CntW'(1);
    localparam logic [CntW-1:0]     RD_LAST   = CntW'(RdWait);
    localparam logic [CntW-1:0]     WR_LAST   = CntW'(WrPulse);
    localparam logic [DataSize-1:0] DATA_ONE  = DataSize'(1);

    // Sequencer state and latched command
    logic [STATE_W-1:0]     state_q, state_d;
    cmd_t                   cmd_q, cmd_d;
    logic [AddressSize-1:0] addr_q, addr_d;
    logic [DataSize-1:0]    data_q, data_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    // Registered outputs
    logic                   busy_q, busy_d;
    logic                   ack_q, ack_d;
    logic [DataSize-1:0]    rdata_q, rdata_d;
    logic                   cs_n_q, cs_n_d;
    logic                   we_n_q, we_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   drive_q, drive_d;

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    cmd_d   = Cmd;
                    addr_d  = Addr;
                    data_d  = WData;
                    state_d = ST_ADDR;
                end
            end

            // One cycle with only CS/address asserted so the address is
            // stable before either strobe falls.
            ST_ADDR: begin
                cnt_d   = CNT_FIRST;
                state_d = cmd_reads(cmd_q) ? ST_RD : ST_WR_SETUP;
            end

            // DATA is captured on the same edge that raises OE_n.
            ST_RD: begin
                if (cnt_q == RD_LAST) begin
                    data_d  = RamData;
                    state_d = cmd_is_rmw(cmd_q) ? ST_TURN : ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_FIRST;
                end
            end

            // The chip stops driving during this cycle; the modified value is
            // ready for WR_SETUP. Wraparound comes from the register width.
            ST_TURN: begin
                data_d  = (cmd_q == CMD_INC) ? (data_q + DATA_ONE)
                                             : (data_q - DATA_ONE);
                state_d = ST_WR_SETUP;
            end

            ST_WR_SETUP: begin
                cnt_d   = CNT_FIRST;
                state_d = ST_WR_PULSE;
            end

            ST_WR_PULSE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_FIRST;
                end
            end

            ST_WR_HOLD: begin
                state_d = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // RData is loaded on entry to DONE so it is valid alongside Ack.
        if (state_d == ST_DONE) begin
            rdata_d = data_d;
        end
    end

    // Chip-facing outputs are decoded from the next state and registered,
    // so the pins are glitch-free and never combinationally follow Req/Cmd.
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        ack_d   = (state_d == ST_DONE);
        cs_n_d  = (state_d == ST_IDLE);
        oe_n_d  = (state_d != ST_RD);
        we_n_d  = (state_d != ST_WR_PULSE);
        drive_d = (state_d == ST_WR_SETUP) ||
                  (state_d == ST_WR_PULSE) ||
                  (state_d == ST_WR_HOLD);
    end

    // Asynchronous reset releases the bus and raises WE_n immediately, even
    // in the middle of a write pulse.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_READ;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            cs_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            cs_n_q  <= cs_n_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            drive_q <= drive_d;
        end
    end

    assign Busy    = busy_q;
    assign Ack     = ack_q;
    assign RData   = rdata_q;
    assign RamAddr = addr_q;
    assign RamCs_n = cs_n_q;
    assign RamWe_n = we_n_q;
    assign RamOe_n = oe_n_q;

    // data_q is stable for the whole write window, so the bus holds one value
    // from WR_SETUP through WR_HOLD.
    assign RamData = drive_q ? data_q : {DataSize{1'bz}};

`ifndef SYNTHESIS
    always @(posedge Clk) begin
        assert (!(!RamWe_n && !RamOe_n))
            else $error("ram_bus_ctrl: RamWe_n and RamOe_n both low");
    end
`endif

endmodule
